// File: rtl/axis_fifo.sv
// ============================================================================
//  Module   : axis_fifo
//  Brief    : First-word-fall-through AXI-Stream FIFO carrying data plus last.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int             c_aw  = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_one = 1;

  logic [DATA_W:0] r_mem [DEPTH];
  logic [c_aw:0]   r_wr_ptr;
  logic [c_aw:0]   r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            r_ready_en;

  logic            w_wr_en;
  logic            w_rd_en;
  logic            w_full;
  logic            w_empty;
  logic [DATA_W:0] w_head;

  // Extra pointer MSB distinguishes the full and empty cases at equal indices.
  assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_wr_en = s_valid && s_ready;
  assign w_rd_en = m_valid && m_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_one;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + c_one;
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset; the empty gating below hides stale data.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= {s_last, s_data};
    end
  end

  assign w_head  = r_mem[r_rd_ptr[c_aw-1:0]];

  assign s_ready = r_ready_en && !w_full;
  assign m_valid = !w_empty;
  assign m_data  = w_empty ? '0   : w_head[DATA_W-1:0];
  assign m_last  = w_empty ? 1'b0 : w_head[DATA_W];
  assign count   = r_count;
  assign full    = w_full;
  assign empty   = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_axis_fifo.sv
// ============================================================================
//  Module   : tb_axis_fifo
//  Brief    : Self-checking bench for axis_fifo (vector table plus sequences).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              reset;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [3:0]        count;
  logic              full;
  logic              empty;

  int checks = 0;
  int errors = 0;

  axis_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [31:0] d;
    logic        l;
    logic        mr;
    logic        emv;
    logic [31:0] ed;
    logic        el;
    logic [3:0]  ec;
    logic        ef;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic sv, input logic [31:0] d, input logic l, input logic mr,
                     input logic emv, input logic [31:0] ed, input logic el,
                     input logic [3:0] ec, input logic ef, input logic er);
    vec_t v;
    v.sv = sv; v.d = d; v.l = l; v.mr = mr;
    v.emv = emv; v.ed = ed; v.el = el; v.ec = ec; v.ef = ef; v.er = er;
    vecs.push_back(v);
  endtask

  // Expected values describe the outputs seen before the edge that applies the inputs.
  task automatic build_table();
    add(1, 32'hA5A5_0001, 0, 0,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,              1, 32'hA5A5_0001, 0, 1, 0, 1);
    add(0, 0, 0, 1,              1, 32'hA5A5_0001, 0, 1, 0, 1);
    for (int i = 1; i <= 8; i++)
      add(1, i, (i == 5), 0, (i > 1), (i > 1) ? 1 : 0, 0, 4'(i - 1), 0, 1);
    add(1, 9, 0, 0,              1, 1, 0, 8, 1, 0);
    add(1, 9, 0, 0,              1, 1, 0, 8, 1, 0);
    add(1, 9, 0, 1,              1, 1, 0, 8, 1, 0);
    add(1, 9, 0, 0,              1, 2, 0, 7, 0, 1);
    for (int j = 0; j < 8; j++)
      add(0, 0, 0, 1, 1, j + 2, (j + 2 == 5), 4'(8 - j), (j == 0), (j != 0));
    add(0, 0, 0, 0,              0, 0, 0, 0, 0, 1);
    add(1, 32'h11, 1, 0,         0, 0, 0, 0, 0, 1);
    add(1, 32'h22, 0, 1,         1, 32'h11, 1, 1, 0, 1);
    add(0, 0, 0, 0,              1, 32'h22, 0, 1, 0, 1);
    add(0, 0, 0, 1,              1, 32'h22, 0, 1, 0, 1);
    add(0, 0, 0, 0,              0, 0, 0, 0, 0, 1);
  endtask

  logic [32:0] sb[$];
  logic [31:0] nxt_data;
  logic        nxt_last;
  int          wr_n, rd_n, cyc;
  logic        hs_w, hs_r;

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    build_table();

    // Reset state, including clock edges with a word offered.
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_mlast", m_last, 0);
    chk("rst_sready", s_ready, 0);
    s_valid = 1'b1; s_data = 32'h1234; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_no_write", count, 0);
    s_valid = 1'b0; m_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("release_sready_low", s_ready, 0);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      s_valid = vecs[i].sv; s_data = vecs[i].d; s_last = vecs[i].l; m_ready = vecs[i].mr;
      @(negedge clk);
      chk($sformatf("v%0d_mvalid", i), m_valid, vecs[i].emv);
      chk($sformatf("v%0d_mdata", i),  m_data,  vecs[i].ed);
      chk($sformatf("v%0d_mlast", i),  m_last,  vecs[i].el);
      chk($sformatf("v%0d_count", i),  count,   vecs[i].ec);
      chk($sformatf("v%0d_full", i),   full,    vecs[i].ef);
      chk($sformatf("v%0d_empty", i),  empty,   !vecs[i].emv);
      chk($sformatf("v%0d_sready", i), s_ready, vecs[i].er);
    end

    // Streaming: one word in and one out per cycle once the first has landed.
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = k; s_last = (k % 4 == 3); m_ready = 1'b1;
      @(negedge clk);
      if (k == 0) begin
        chk("stream_start_mvalid", m_valid, 0);
      end else begin
        chk($sformatf("stream%0d_mdata", k), m_data, k - 1);
        chk($sformatf("stream%0d_mlast", k), m_last, ((k - 1) % 4 == 3));
        chk($sformatf("stream%0d_count", k), count, 1);
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("stream_tail_mdata", m_data, 20);
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("stream_drained", empty, 1);

    // Random traffic against a scoreboard.
    wr_n = 0; rd_n = 0; cyc = 0;
    nxt_data = $urandom; nxt_last = 1'($urandom_range(0, 1));
    while (rd_n < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      s_valid = (wr_n < 1000) && ($urandom_range(0, 1) == 1);
      s_data  = nxt_data;
      s_last  = nxt_last;
      m_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      chk("rnd_count", count, sb.size());
      chk("rnd_mvalid", m_valid, sb.size() > 0);
      chk("rnd_sready", s_ready, sb.size() < DEPTH);
      if (sb.size() > 0) chk("rnd_head", {m_last, m_data}, sb[0]);
      hs_w = s_valid && (sb.size() < DEPTH);
      hs_r = m_ready && (sb.size() > 0);
      if (hs_r) begin
        void'(sb.pop_front());
        rd_n++;
      end
      if (hs_w) begin
        sb.push_back({nxt_last, nxt_data});
        wr_n++;
        nxt_data = $urandom; nxt_last = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    chk("rnd_words_read", rd_n, 1000);

    // Reset asserted with five words stored.
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 32'h100 + i; s_last = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_count", count, 5);
    #2 reset = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_mvalid", m_valid, 0);
    chk("midrst_mdata", m_data, 0);
    chk("midrst_sready", s_ready, 0);
    s_valid = 1'b1; s_data = 32'h55; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_write", count, 0);
    s_valid = 1'b0; m_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_mvalid", m_valid, 1);
    chk("post_rst_head", {m_last, m_data}, {1'b1, 32'hDEAD_BEEF});
    chk("post_rst_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
